// File: rtl/fp_serial_mac_pkg.sv
// Shared types and fixed-point width helpers for the serial dot-product MAC.
// Widths split evenly: upper half integer, lower half fraction.
package fp_serial_mac_pkg;

    typedef enum logic [0:0] {
        StAcc,
        StDone
    } mac_state_e;

    function automatic int unsigned int_bits(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned frac_bits(input int unsigned width);
        return width - (width / 2);
    endfunction

    // Headroom of clog2(len) bits keeps len full-scale products from overflowing.
    function automatic int unsigned acc_width(input int unsigned in_width,
                                              input int unsigned len);
        return 2 * in_width + $clog2(len);
    endfunction

endpackage

// File: rtl/fp_quant_sat.sv
// Combinational fixed-point requantizer: truncates surplus fraction bits and
// saturates to all-ones when the retained integer part does not fit.
module fp_quant_sat #(
    parameter int unsigned IN_INT_W   = 18,
    parameter int unsigned IN_FRAC_W  = 16,
    parameter int unsigned OUT_INT_W  = 8,
    parameter int unsigned OUT_FRAC_W = 8
) (
    input  logic [IN_INT_W+IN_FRAC_W-1:0]   data_i,
    output logic [OUT_INT_W+OUT_FRAC_W-1:0] data_o,
    output logic                            sat_o
);

    localparam int unsigned IN_W   = IN_INT_W + IN_FRAC_W;
    localparam int unsigned OUT_W  = OUT_INT_W + OUT_FRAC_W;
    localparam int unsigned DROP   = IN_FRAC_W - OUT_FRAC_W;
    localparam int unsigned KEEP_W = IN_W - DROP;

    logic [KEEP_W-1:0] kept;

    assign kept = data_i[IN_W-1:DROP];

    if (KEEP_W > OUT_W) begin : g_sat
        logic ovf;
        assign ovf    = |kept[KEEP_W-1:OUT_W];
        assign data_o = ovf ? '1 : kept[OUT_W-1:0];
        assign sat_o  = ovf;
    end else begin : g_nosat
        assign data_o = OUT_W'(kept);
        assign sat_o  = 1'b0;
    end

endmodule

// File: rtl/fp_serial_mac.sv
// Serial fixed-point dot product: accepts one element pair per cycle, presents
// the quantized sum after DATA_LENGTH pairs and holds it until drained.
module fp_serial_mac
    import fp_serial_mac_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH  = 16,
    parameter int unsigned OUTPUT_DATA_WIDTH = 16,
    parameter int unsigned DATA_LENGTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INPUT_DATA_WIDTH-1:0]  in_a,
    input  logic [INPUT_DATA_WIDTH-1:0]  in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
    output logic                         out_sat
);

    localparam int unsigned ACC_W    = acc_width(INPUT_DATA_WIDTH, DATA_LENGTH);
    localparam int unsigned ACC_FRAC = 2 * frac_bits(INPUT_DATA_WIDTH);
    localparam int unsigned CNT_W    = $clog2(DATA_LENGTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_LENGTH - 1);

    mac_state_e state_q, state_d;

    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [OUTPUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_sat_q, out_sat_d;

    logic [2*INPUT_DATA_WIDTH-1:0] prod;
    logic [ACC_W-1:0]              sum;
    logic [OUTPUT_DATA_WIDTH-1:0]  q_data;
    logic                          q_sat;
    logic                          acc_en;
    logic                          last_beat;

    assign prod      = in_a * in_b;
    assign sum       = acc_q + ACC_W'(prod);
    // clr wins over a simultaneous pair, which is then dropped.
    assign acc_en    = (state_q == StAcc) && in_valid && !clr;
    assign last_beat = acc_en && (cnt_q == LAST_CNT);

    fp_quant_sat #(
        .IN_INT_W   (ACC_W - ACC_FRAC),
        .IN_FRAC_W  (ACC_FRAC),
        .OUT_INT_W  (int_bits(OUTPUT_DATA_WIDTH)),
        .OUT_FRAC_W (frac_bits(OUTPUT_DATA_WIDTH))
    ) u_quant (
        .data_i (sum),
        .data_o (q_data),
        .sat_o  (q_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc:   if (last_beat) state_d = StDone;
            StDone:  if (out_ready) state_d = StAcc;
            default: state_d = StAcc;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StAcc:   in_ready  = 1'b1;
            StDone:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (state_q == StAcc) begin
            if (clr) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (last_beat) begin
                acc_d      = '0;
                cnt_d      = '0;
                out_data_d = q_data;
                out_sat_d  = q_sat;
            end else if (acc_en) begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign out_data = out_data_q;
    assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_fp_serial_mac.sv
// Directed bench for fp_serial_mac: inputs driven on the falling edge, outputs
// sampled on the falling edge before new stimulus is applied.
module tb_fp_serial_mac;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int n_total = 0;
    int n_pass  = 0;

    fp_serial_mac #(
        .INPUT_DATA_WIDTH  (16),
        .OUTPUT_DATA_WIDTH (16),
        .DATA_LENGTH       (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic feed(input string tag, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, " out_valid low"}, 32'(out_valid), 32'd0);
        clr      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    // Result must appear exactly one cycle after the last pair, then drain.
    task automatic finish_dot(input string tag, input logic [15:0] exp_data, input logic exp_sat);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, " in_ready low"}, 32'(in_ready), 32'd0);
        check_eq({tag, " out_data"}, 32'(out_data), 32'(exp_data));
        check_eq({tag, " out_sat"}, 32'(out_sat), 32'(exp_sat));
        @(negedge clk);
        check_eq({tag, " drained"}, 32'(out_valid), 32'd0);
        check_eq({tag, " ready again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #2;
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst out_data", 32'(out_data), 32'd0);
        check_eq("rst out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 * 1.0 summed four times.
        for (int i = 0; i < 4; i++) feed("unit", 16'h0100, 16'h0100);
        finish_dot("unit", 16'h0400, 1'b0);

        // 127^2 * 4 overflows the 8-bit integer field.
        for (int i = 0; i < 4; i++) feed("sat", 16'h7F00, 16'h7F00);
        finish_dot("sat", 16'hFFFF, 1'b1);

        // 1.5*2 + 0.25*1 + 0 + 2^-16 -> 3.25 with the tiny term truncated.
        feed("mix", 16'h0180, 16'h0200);
        feed("mix", 16'h0040, 16'h0100);
        feed("mix", 16'h0000, 16'hFFFF);
        feed("mix", 16'h0001, 16'h0001);
        finish_dot("mix", 16'h0340, 1'b0);

        // Backpressure: pairs and clr presented while the result is pending.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed("hold", 16'h0100, 16'h0100);
        @(negedge clk);
        check_eq("hold out_valid", 32'(out_valid), 32'd1);
        check_eq("hold out_data", 32'(out_data), 32'h0400);
        for (int i = 0; i < 5; i++) begin
            clr = 1'b1;
            @(negedge clk);
            check_eq("hold in_ready", 32'(in_ready), 32'd0);
            check_eq("hold valid kept", 32'(out_valid), 32'd1);
            check_eq("hold data kept", 32'(out_data), 32'h0400);
        end
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("release out_valid", 32'(out_valid), 32'd0);
        check_eq("release in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) feed("after_hold", 16'h0200, 16'h0100);
        finish_dot("after_hold", 16'h0800, 1'b0);

        // clr discards two accepted pairs and the pair presented alongside it.
        feed("clr", 16'h0300, 16'h0100);
        feed("clr", 16'h0300, 16'h0100);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'h0500;
        in_b     = 16'h0100;
        for (int i = 0; i < 4; i++) feed("post_clr", 16'h0100, 16'h0100);
        finish_dot("post_clr", 16'h0400, 1'b0);

        // Asynchronous reset mid-accumulation; out_data held 0400 beforehand.
        for (int i = 0; i < 3; i++) feed("rst_mid", 16'h0100, 16'h0100);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_mid out_data", 32'(out_data), 32'd0);
        check_eq("rst_mid out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) feed("post_rst", 16'h0100, 16'h0100);
        finish_dot("post_rst", 16'h0400, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_serial_mac.md
FP_SERIAL_MAC -- requirements
Module: fp_serial_mac

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 16: input element width, unsigned fixed point, upper half integer, lower half fraction.
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 16: result width, unsigned fixed point, upper half integer, lower half fraction.
REQ-003 SHALL have parameter DATA_LENGTH, default 4: number of element pairs per dot product; must be at least 2.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port clr, input, 1 bit: synchronous discard of a partial accumulation.
REQ-008 SHALL have port in_valid, input, 1 bit: element pair valid.
REQ-009 SHALL have port in_ready, output, 1 bit: element pair accepted this cycle when high with in_valid.
REQ-010 SHALL have port in_a, input, INPUT_DATA_WIDTH bits: first operand.
REQ-011 SHALL have port in_b, input, INPUT_DATA_WIDTH bits: second operand.
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have port out_data, output, OUTPUT_DATA_WIDTH bits: quantized dot product.
REQ-015 SHALL have port out_sat, output, 1 bit: out_data was saturated.

Function
REQ-016 SHALL implement a two-state FSM. In ACC, in_ready=1 and out_valid=0. In DONE, in_ready=0 and out_valid=1.
REQ-017 SHALL, in ACC on a handshake (in_valid and in_ready), add in_a*in_b to the accumulator and increment the element counter. Throughput is one pair per cycle.
REQ-018 SHALL size the accumulator at 2*INPUT_DATA_WIDTH+$clog2(DATA_LENGTH) bits, so that no overflow occurs before quantization.
REQ-019 SHALL, on the DATA_LENGTH-th handshake:
- register out_data and out_sat from the final sum (current product included);
- enter DONE;
- assert out_valid the following cycle (latency 1 cycle from the last accepted pair).
REQ-020 SHALL quantize as follows:
- drop the (INPUT_DATA_WIDTH - OUTPUT_DATA_WIDTH/2) fractional LSBs by truncation;
- if any bit above the OUTPUT_DATA_WIDTH retained bits is set, output all-ones and set out_sat=1;
- otherwise set out_sat=0.
REQ-021 SHALL hold out_data and out_sat stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on out_valid and out_ready:
- clear the accumulator and counter;
- return to ACC, with in_ready=1 the next cycle;
- deassert out_valid the next cycle.
No bypass from DONE to ACC in the same cycle.
REQ-023 SHALL, when clr=1 in ACC, zero the accumulator and counter. clr takes priority over a simultaneous input handshake, and that pair is discarded.
REQ-024 SHALL ignore clr while in DONE; the pending result is preserved.
REQ-025 SHALL wrap the element counter from DATA_LENGTH-1 to 0 on entry to DONE.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously force the following state:
- FSM to ACC;
- accumulator and counter to 0;
- out_valid=0, out_data=0, out_sat=0;
- in_ready=1 after reset release.
REQ-027 SHALL, on reset asserted mid-accumulation or in DONE, discard all partial and pending results.

Structure
REQ-028 SHALL place the fixed-point width helpers in the shared package: integer/fraction split and accumulator width function.
REQ-029 SHALL implement truncation/saturation in one sub-module, fp_quant_sat, which is combinational and parameterized by input/output integer and fraction widths.
REQ-030 SHALL keep the FSM, counter and accumulator in fp_serial_mac.

Verification (defaults, values in hex)
REQ-031 SHALL cover: four pairs 0100*0100 back-to-back with out_ready=1 -> out_data=0400, out_sat=0, out_valid exactly 1 cycle after the 4th handshake.
REQ-032 SHALL cover: four pairs 7F00*7F00 -> out_data=FFFF, out_sat=1.
REQ-033 SHALL cover: pairs 0180*0200, 0040*0100, 0000*FFFF, 0001*0001 -> out_data=0340 (fraction truncated), out_sat=0.
REQ-034 SHALL cover: result pending with out_ready=0 for 5 cycles, in_valid=1 throughout -> in_ready=0, out_data stable, no pair accepted; accept resumes the cycle after out_ready=1.
REQ-035 SHALL cover: two pairs accepted, then clr=1 with in_valid=1, then four 0100*0100 pairs -> out_data=0400.
REQ-036 SHALL cover: rst_n pulsed low after three pairs -> outputs 0 immediately; the next four 0100*0100 pairs -> out_data=0400.
